// File: rtl/param_key_shifter.sv
// param_key_shifter: seeded key-word generator feeding the one-time-pad XOR stage.
// A seed is loaded through a valid/ready handshake, then KEY_W-bit words are taken
// from the register MSBs and the register advances by a programmable step/mode
// after every accepted word.
// Optional build macro: KEY_LFSR_EN (mode 11 becomes a Galois LFSR using POLY;
// without it mode 11 is a plain rotate-left and no LFSR logic exists).
module param_key_shifter #(
    parameter int MSG_W  = 240,
    parameter int KEY_W  = 64,
    parameter int STEP_W = $clog2(MSG_W),
    parameter int CNT_W  = 16
`ifdef KEY_LFSR_EN
    ,
    parameter logic [MSG_W-1:0] POLY = MSG_W'('h2D)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [MSG_W-1:0]  msg_in,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              abort,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [KEY_W-1:0]  key_out,
    output logic [CNT_W-1:0]  words_left,
    output logic              done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [MSG_W-1:0]   shreg, shreg_next;
    logic [1:0]         mode_q;
    logic [STEP_W-1:0]  step_q;
    logic [STEP_W-1:0]  rot_amt;
    logic [2*MSG_W-1:0] rot_left_wide, rot_right_wide;
    logic               done_q;
    logic               load_fire, xfer, last_xfer;

    assign key_out = shreg[MSG_W-1 -: KEY_W];
    assign done    = done_q & enable;

    // State register; everything freezes while enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; abort wins over a simultaneous transfer.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        key_valid  = 1'b0;
        load_fire  = 1'b0;
        xfer       = 1'b0;
        last_xfer  = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    load_ready = 1'b1;
                    if (load_valid) begin
                        load_fire  = 1'b1;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    key_valid = 1'b1;
                    if (abort) begin
                        state_next = IDLE;
                    end else if (key_ready) begin
                        xfer = 1'b1;
                        if (words_left == CNT_W'(1)) begin
                            last_xfer  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Register advance: shift, rotate (step taken modulo the register width) or LFSR.
    always_comb begin
        rot_amt        = STEP_W'(step_q % MSG_W);
        rot_left_wide  = {shreg, shreg} << rot_amt;
        rot_right_wide = {shreg, shreg} >> rot_amt;
        shreg_next     = shreg;
        case (mode_q)
            2'b00: shreg_next = shreg << step_q;
            2'b01: shreg_next = rot_left_wide[2*MSG_W-1 -: MSG_W];
            2'b10: shreg_next = rot_right_wide[MSG_W-1:0];
`ifdef KEY_LFSR_EN
            2'b11: shreg_next = (shreg >> 1) ^ (shreg[0] ? POLY : '0);
`else
            2'b11: shreg_next = rot_left_wide[2*MSG_W-1 -: MSG_W];
`endif
            default: shreg_next = shreg;
        endcase
    end

    // Seed/config capture on load, advance and count down on each accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            mode_q     <= '0;
            step_q     <= '0;
            words_left <= '0;
        end else if (load_fire) begin
            shreg      <= msg_in;
            mode_q     <= mode;
            step_q     <= step;
            words_left <= num_words;
        end else if (xfer) begin
            shreg <= shreg_next;
            if (words_left != '0) begin
                words_left <= words_left - CNT_W'(1);
            end
        end
    end

    // Done flag is held while disabled so the pulse appears on the next enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else if (enable) begin
            done_q <= last_xfer;
        end
    end

endmodule

// File: tb/tb_param_key_shifter.sv
// Testbench for param_key_shifter (16-bit register, 8-bit key words, 4-bit count).
// Directed sequences pin literal key words; a random phase is checked every cycle
// against a word-level behavioural model. Honours KEY_LFSR_EN when defined.
module tb_param_key_shifter;

    localparam int MW = 16;
    localparam int KW = 8;
    localparam int SW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [MW-1:0] msg_in = '0;
    logic [1:0]    mode = '0;
    logic [SW-1:0] step = '0;
    logic [CW-1:0] num_words = '0;
    logic          abort = 1'b0;
    logic          key_valid;
    logic          key_ready = 1'b1;
    logic [KW-1:0] key_out;
    logic [CW-1:0] words_left;
    logic          done;

    int tests_run = 0;
    int tests_failed = 0;
    bit checking = 1'b0;

    // Word-level model of the generator
    bit          m_run = 1'b0;
    bit          m_done = 1'b0;
    logic [15:0] m_reg = '0;
    logic [1:0]  m_mode = '0;
    int          m_step = 0;
    int          m_left = 0;

    param_key_shifter #(
        .MSG_W(MW), .KEY_W(KW), .STEP_W(SW), .CNT_W(CW)
`ifdef KEY_LFSR_EN
        , .POLY(16'hB400)
`endif
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load_valid(load_valid),
        .load_ready(load_ready), .msg_in(msg_in), .mode(mode), .step(step),
        .num_words(num_words), .abort(abort), .key_valid(key_valid),
        .key_ready(key_ready), .key_out(key_out), .words_left(words_left), .done(done)
    );

    always #5 clk = ~clk;

    // Advance a 16-bit value one bit position at a time, as the mode describes
    function automatic logic [15:0] model_next(logic [15:0] v, logic [1:0] md, int st);
        logic [15:0] r;
        r = v;
        case (md)
            2'b00: for (int i = 0; i < st; i++) r = {r[14:0], 1'b0};
            2'b10: for (int i = 0; i < st % 16; i++) r = {r[0], r[15:1]};
`ifdef KEY_LFSR_EN
            2'b11: r = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
`endif
            default: for (int i = 0; i < st % 16; i++) r = {r[14:0], r[15]};
        endcase
        return r;
    endfunction

    task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(logic lv, logic [15:0] seed, logic [1:0] md,
                                 logic [SW-1:0] st, logic [CW-1:0] cnt);
        load_valid = lv;
        msg_in     = seed;
        mode       = md;
        step       = st;
        num_words  = cnt;
    endtask

    // Model update on every clock edge, asynchronous reset included
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_done = 0; m_reg = '0; m_mode = '0; m_step = 0; m_left = 0;
        end else if (enable) begin
            m_done = 0;
            if (!m_run) begin
                if (load_valid) begin
                    m_reg = msg_in; m_mode = mode; m_step = int'(step);
                    m_left = int'(num_words); m_run = 1;
                end
            end else if (abort) begin
                m_run = 0;
            end else if (key_ready) begin
                m_reg = model_next(m_reg, m_mode, m_step);
                if (m_left == 1) begin
                    m_run = 0;
                    m_done = 1;
                end
                if (m_left != 0) m_left = m_left - 1;
            end
        end
    end

    // Every-cycle comparison against the model, well clear of the rising edge
    always @(negedge clk) begin
        if (checking) begin
            #3;
            checkOutput("cyc.key_valid", 32'(key_valid), 32'(enable & m_run));
            checkOutput("cyc.load_ready", 32'(load_ready), 32'(enable & !m_run));
            checkOutput("cyc.key_out", 32'(key_out), 32'(m_reg[15:8]));
            checkOutput("cyc.words_left", 32'(words_left), 32'(m_left[3:0]));
            checkOutput("cyc.done", 32'(done), 32'(enable & m_done));
        end
    end

    // Load one counted stream and pin each word literally
    task automatic run_words(string name, logic [15:0] seed, logic [1:0] md,
                             logic [SW-1:0] st, logic [CW-1:0] cnt, logic [31:0] words, int n);
        @(negedge clk);
        applyStimulus(1'b1, seed, md, st, cnt);
        #4 checkOutput($sformatf("%s.load_ready", name), 32'(load_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #4;
            checkOutput($sformatf("%s.kv%0d", name, i), 32'(key_valid), 32'd1);
            checkOutput($sformatf("%s.key%0d", name, i), 32'(key_out), 32'(words[31-8*i -: 8]));
            checkOutput($sformatf("%s.left%0d", name, i), 32'(words_left), 32'(4'(cnt - 4'(i))));
        end
        @(negedge clk);
        #4;
        checkOutput($sformatf("%s.kv_end", name), 32'(key_valid), 32'd0);
        checkOutput($sformatf("%s.done", name), 32'(done), 32'd1);
        checkOutput($sformatf("%s.left_end", name), 32'(words_left), 32'd0);
    endtask

    logic [39:0] freerun_words;

    initial begin
        #1 rst = 1'b1;
        checking = 1'b1;
        @(negedge clk);
        #4;
        checkOutput("reset.key_valid", 32'(key_valid), 32'd0);
        checkOutput("reset.key_out", 32'(key_out), 32'd0);
        checkOutput("reset.words_left", 32'(words_left), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic counted streams in each shift mode
        run_words("rotl", 16'hABCD, 2'b01, 5'd4, 4'd3, {8'hAB, 8'hBC, 8'hCD, 8'h00}, 3);
        @(negedge clk); #4 checkOutput("rotl.done_clear", 32'(done), 32'd0);
        run_words("rotr", 16'hABCD, 2'b10, 5'd4, 4'd2, {8'hAB, 8'hDA, 16'h0}, 2);
        run_words("shl8", 16'hABCD, 2'b00, 5'd8, 4'd3, {8'hAB, 8'hCD, 8'h00, 8'h00}, 3);
        run_words("shl20", 16'hABCD, 2'b00, 5'd20, 4'd2, {8'hAB, 8'h00, 16'h0}, 2);
        run_words("rot20", 16'hABCD, 2'b01, 5'd20, 4'd2, {8'hAB, 8'hBC, 16'h0}, 2);
`ifdef KEY_LFSR_EN
        run_words("mode3", 16'h0001, 2'b11, 5'd12, 4'd2, {8'h00, 8'hB4, 16'h0}, 2);
`else
        run_words("mode3", 16'h0001, 2'b11, 5'd12, 4'd2, {8'h00, 8'h10, 16'h0}, 2);
`endif

        // Backpressure, then enable freeze, then resume on the same word
        @(negedge clk);
        applyStimulus(1'b1, 16'hABCD, 2'b01, 5'd4, 4'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            key_ready  = 1'b0;
            #4;
            checkOutput("bp.key", 32'(key_out), 32'hAB);
            checkOutput("bp.left", 32'(words_left), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            enable = 1'b0;
            #4;
            checkOutput("freeze.kv", 32'(key_valid), 32'd0);
            checkOutput("freeze.key", 32'(key_out), 32'hAB);
        end
        @(negedge clk);
        enable = 1'b1; key_ready = 1'b1;
        #4 checkOutput("resume.key", 32'(key_out), 32'hAB);
        @(negedge clk); #4 checkOutput("resume.key2", 32'(key_out), 32'hBC);
        @(negedge clk); #4 checkOutput("resume.key3", 32'(key_out), 32'hCD);
        // Reload in the same cycle the done pulse is visible
        @(negedge clk);
        applyStimulus(1'b1, 16'h1234, 2'b00, 5'd4, 4'd1);
        #4;
        checkOutput("reload.done", 32'(done), 32'd1);
        checkOutput("reload.ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        #4 checkOutput("reload.key", 32'(key_out), 32'h12);
        @(negedge clk); #4 checkOutput("reload.done2", 32'(done), 32'd1);

        // Free-running stream, aborted together with a transfer
        freerun_words = {8'hAB, 8'hBC, 8'hCD, 8'hDA, 8'hAB};
        @(negedge clk);
        applyStimulus(1'b1, 16'hABCD, 2'b01, 5'd4, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            if (i == 4) abort = 1'b1;
            #4;
            checkOutput($sformatf("free.key%0d", i), 32'(key_out), 32'(freerun_words[39-8*i -: 8]));
            checkOutput($sformatf("free.left%0d", i), 32'(words_left), 32'd0);
        end
        @(negedge clk);
        abort = 1'b0;
        #4;
        checkOutput("abort.kv", 32'(key_valid), 32'd0);
        checkOutput("abort.done", 32'(done), 32'd0);
        checkOutput("abort.key", 32'(key_out), 32'hAB);

        // Asynchronous reset in the middle of a stream
        @(negedge clk);
        applyStimulus(1'b1, 16'hABCD, 2'b01, 5'd4, 4'd3);
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst.kv", 32'(key_valid), 32'd0);
        checkOutput("arst.key", 32'(key_out), 32'd0);
        checkOutput("arst.left", 32'(words_left), 32'd0);
        #4 rst = 1'b0;
        @(negedge clk);
        #4 checkOutput("arst.ready", 32'(load_ready), 32'd1);

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            applyStimulus($urandom_range(0, 3) == 0, 16'($urandom), 2'($urandom),
                          5'($urandom_range(0, 20)), 4'($urandom_range(0, 5)));
            abort     = ($urandom_range(0, 19) == 0);
            key_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 9) != 0);
        end
        @(negedge clk);
        #4;
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
